pixel_framebuffer: RTL and testbench

- Receiving end of the pixel write stream (x, y, colour, writeEn) that the movement datapath emits.
- Stores pixels in an on-chip frame buffer and flags a collision when a non-black pixel lands on an already non-black pixel; the light-trail game uses this as its crash signal.
- Runs a raster scan that reads the buffer back for display.
- Provides a full-screen clear sweep, run on reset and on request.

---
 rtl/pixel_framebuffer_if.sv | 26 ++
 rtl/pixel_framebuffer.sv | 184 ++++++++++++++++++
 tb/tb_pixel_framebuffer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_framebuffer_if.sv
// ---------------------------------------------------------------------------
// pixel_framebuffer_if
// Pixel write stream from the movement datapath into the frame buffer.
//
// Handshake: pix_we is the valid strobe and qualifies pix_x/pix_y/pix_color
// in the same cycle. There is no ready signal. Every strobed pixel is taken
// in the cycle it is presented, one per cycle. The exception is while the
// frame buffer reports busy, or in the cycle clear_all is requested; pixels
// strobed then are dropped.
//
// Signals:
//   pix_x      7  write column
//   pix_y      7  write row
//   pix_color  3  write colour, 3'b000 = black/erase
//   pix_we     1  write strobe
// Modports: master (datapath side, drives), slave (frame buffer side).
// ---------------------------------------------------------------------------
interface pixel_framebuffer_if;
    logic [6:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_color;
    logic       pix_we;

    modport master (output pix_x, pix_y, pix_color, pix_we);
    modport slave  (input  pix_x, pix_y, pix_color, pix_we);
endinterface

// File: rtl/pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// pixel_framebuffer
// On-chip frame buffer for the light-trail game. It stores incoming pixels
// and pulses collision when a non-black pixel lands on a non-black one. It
// also runs a raster scan that reads the buffer back for display, and it
// provides a full-screen clear sweep that runs on reset and on request.
//
// Ports:
//   clk, reset_n   clock; synchronous active-low reset
//   wr             pixel write stream (pixel_framebuffer_if.slave)
//   clear_all      request a full-buffer clear to black
//   busy           clear sweep in progress; writes are ignored
//   collision      one-cycle pulse, two cycles after the colliding pix_we
//   coll_x/coll_y  coordinates of the most recent collision (held)
//   oob            one-cycle pulse, the previous write was out of range
//   scan_x/scan_y  raster position described by scan_color
//   scan_color     buffer contents at scan_x/scan_y, 0 outside active area
//   scan_active    scan position lies inside the visible area
//   frame_start    pulse at raster position (0,0)
//   dbg_state      FSM state (0 = CLEAR, 1 = IDLE)
// ---------------------------------------------------------------------------
module pixel_framebuffer #(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 120,
    parameter int H_TOTAL = 160,
    parameter int V_TOTAL = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pixel_framebuffer_if.slave   wr,
    input  logic                 clear_all,
    output logic                 busy,
    output logic                 collision,
    output logic [6:0]           coll_x,
    output logic [6:0]           coll_y,
    output logic                 oob,
    output logic [7:0]           scan_x,
    output logic [7:0]           scan_y,
    output logic [2:0]           scan_color,
    output logic                 scan_active,
    output logic                 frame_start,
    output logic                 dbg_state
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [7:0]    W8        = 8'(WIDTH);
    localparam logic [7:0]    H8        = 8'(HEIGHT);
    localparam logic [7:0]    H_LAST    = 8'(H_TOTAL - 1);
    localparam logic [7:0]    V_LAST    = 8'(V_TOTAL - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] clr_addr;

    // Write stage S1: holds an accepted pixel for the cycle in which its old
    // contents are read and the new colour is committed.
    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    logic [2:0]    s1_color;
    logic [6:0]    s1_x;
    logic [6:0]    s1_y;
    logic [2:0]    old_color;

    logic          wr_in_range;
    logic          wr_take;
    logic [AW-1:0] wr_addr;

    logic [7:0]    h_cnt;
    logic [7:0]    v_cnt;
    logic          cnt_active;
    logic [AW-1:0] scan_addr;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_addr == LAST_ADDR) state_d = S_IDLE;
            S_IDLE:  if (clear_all)             state_d = S_CLEAR;
            default: state_d = S_CLEAR;
        endcase
    end

    assign busy      = (state_q == S_CLEAR);
    assign dbg_state = state_q;

    // ---------------- write path ----------------
    assign wr_in_range = ({1'b0, wr.pix_x} < W8) && ({1'b0, wr.pix_y} < H8);
    // A clear request in the same cycle takes priority over a strobed pixel.
    assign wr_take     = (state_q == S_IDLE) && !clear_all && wr.pix_we;
    assign wr_addr     = AW'(wr.pix_y) * AW'(WIDTH) + AW'(wr.pix_x);
    assign old_color   = mem[s1_addr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_color  <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            collision <= 1'b0;
            coll_x    <= '0;
            coll_y    <= '0;
            oob       <= 1'b0;
        end else begin
            // Clear address wraps back to 0 after the last cell, so the next sweep starts there.
            if (state_q == S_CLEAR)
                clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
            else
                clr_addr <= '0;

            s1_valid <= wr_take && wr_in_range;
            if (wr_take && wr_in_range) begin
                s1_addr  <= wr_addr;
                s1_color <= wr.pix_color;
                s1_x     <= wr.pix_x;
                s1_y     <= wr.pix_y;
            end

            oob <= wr_take && !wr_in_range;

            // old_color already reflects a write committed at the edge that
            // loaded S1, so back-to-back writes to one cell need no forwarding.
            collision <= s1_valid && (s1_color != 3'd0) && (old_color != 3'd0);
            if (s1_valid && (s1_color != 3'd0) && (old_color != 3'd0)) begin
                coll_x <= s1_x;
                coll_y <= s1_y;
            end
        end
    end

    // Single write port. S1 can only be valid in the cycle after an IDLE
    // cycle without clear_all, so it never competes with the sweep.
    always_ff @(posedge clk) begin
        if (s1_valid)
            mem[s1_addr] <= s1_color;
        else if (state_q == S_CLEAR)
            mem[clr_addr] <= 3'd0;
    end

    // ---------------- raster scan ----------------
    assign cnt_active = (h_cnt < W8) && (v_cnt < H8);
    assign scan_addr  = AW'(v_cnt) * AW'(WIDTH) + AW'(h_cnt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            scan_x      <= '0;
            scan_y      <= '0;
            scan_color  <= '0;
            scan_active <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            scan_x      <= h_cnt;
            scan_y      <= v_cnt;
            scan_active <= cnt_active;
            scan_color  <= cnt_active ? mem[scan_addr] : 3'd0;
            frame_start <= (h_cnt == 8'd0) && (v_cnt == 8'd0);
        end
    end

endmodule

// File: tb/tb_pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_framebuffer
// Directed steps plus randomized writes, checked every cycle against a
// behavioural model: a 2-D colour array, a busy countdown, and raster
// position derived arithmetically from the cycle count since reset release.
// ---------------------------------------------------------------------------
module tb_pixel_framebuffer;

    localparam int WIDTH   = 128;
    localparam int HEIGHT  = 120;
    localparam int H_TOTAL = 160;
    localparam int V_TOTAL = 128;
    localparam int SWEEP   = WIDTH * HEIGHT;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_all = 1'b0;
    logic       busy, collision, oob, scan_active, frame_start, dbg_state;
    logic [6:0] coll_x, coll_y;
    logic [7:0] scan_x, scan_y;
    logic [2:0] scan_color;

    pixel_framebuffer_if bus ();

    pixel_framebuffer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (bus.slave),
        .clear_all   (clear_all),
        .busy        (busy),
        .collision   (collision),
        .coll_x      (coll_x),
        .coll_y      (coll_y),
        .oob         (oob),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_color  (scan_color),
        .scan_active (scan_active),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [2:0] ref_mem [HEIGHT][WIDTH];
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         cyc       = 0;
    int         busy_left = 0;
    int         last_we   = -100;
    int         last_busy = -100;
    logic       exp_coll_now = 1'b0, exp_coll_next = 1'b0, exp_oob_now = 1'b0;
    logic [6:0] exp_cx = '0, exp_cy = '0, pend_cx = '0, pend_cy = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Check the current cycle's outputs, drive this cycle's inputs, update
    // the model, then advance to the next cycle (sampling #1 after the edge).
    task automatic step(input logic we, input logic [6:0] x, input logic [6:0] y,
                        input logic [2:0] c, input logic clr);
        logic       exp_busy;
        logic       new_coll, new_oob, act;
        logic [6:0] ncx, ncy;
        int         pk, h, v;

        exp_busy = (busy_left > 0);
        chk("busy", busy, exp_busy);
        chk("collision", collision, exp_coll_now);
        chk("oob", oob, exp_oob_now);
        chk("coll_x", coll_x, exp_cx);
        chk("coll_y", coll_y, exp_cy);

        if (cyc == 0) begin
            chk("scan_x_first", scan_x, 0);
            chk("frame_start_first", frame_start, 0);
        end else begin
            pk  = cyc - 1;
            h   = pk % H_TOTAL;
            v   = (pk / H_TOTAL) % V_TOTAL;
            act = (h < WIDTH) && (v < HEIGHT);
            chk("scan_x", scan_x, h);
            chk("scan_y", scan_y, v);
            chk("scan_active", scan_active, act);
            chk("frame_start", frame_start, (h == 0) && (v == 0));
            if (!act)
                chk("scan_color_blank", scan_color, 0);
            else if ((cyc - last_we > 3) && (cyc - last_busy > 2))
                chk("scan_color", scan_color, ref_mem[v][h]);
        end

        bus.pix_we    = we;
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.pix_color = c;
        clear_all     = clr;

        new_coll = 1'b0;
        new_oob  = 1'b0;
        ncx      = '0;
        ncy      = '0;
        if (!exp_busy && !clr && we) begin
            if (int'(y) < HEIGHT && int'(x) < WIDTH) begin
                if (c != 3'd0 && ref_mem[y][x] != 3'd0) begin
                    new_coll = 1'b1;
                    ncx      = x;
                    ncy      = y;
                end
                ref_mem[y][x] = c;
                last_we       = cyc;
            end else begin
                new_oob = 1'b1;
            end
        end
        if (exp_busy) last_busy = cyc;
        if (busy_left > 0) busy_left--;
        if (!exp_busy && clr) begin
            for (int yy = 0; yy < HEIGHT; yy++)
                for (int xx = 0; xx < WIDTH; xx++)
                    ref_mem[yy][xx] = 3'd0;
            busy_left = SWEEP;
        end

        @(posedge clk);
        #1;
        cyc++;
        exp_oob_now  = new_oob;
        exp_coll_now = exp_coll_next;
        if (exp_coll_next) begin
            exp_cx = pend_cx;
            exp_cy = pend_cy;
        end
        exp_coll_next = new_coll;
        pend_cx       = ncx;
        pend_cy       = ncy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'd0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic wr_px(input int x, input int y, input int c);
        step(1'b1, 7'(x), 7'(y), 3'(c), 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.pix_we    = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.pix_color = '0;
        for (int yy = 0; yy < HEIGHT; yy++)
            for (int xx = 0; xx < WIDTH; xx++)
                ref_mem[yy][xx] = 3'd0;

        // Reset for two edges, then check reset values.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_collision", collision, 0);
        chk("rst_oob", oob, 0);
        chk("rst_coll_x", coll_x, 0);
        chk("rst_coll_y", coll_y, 0);
        chk("rst_scan_x", scan_x, 0);
        chk("rst_scan_y", scan_y, 0);
        chk("rst_scan_color", scan_color, 0);
        chk("rst_scan_active", scan_active, 0);
        chk("rst_frame_start", frame_start, 0);

        // Release: this cycle is the first of the power-on sweep.
        reset_n   = 1'b1;
        busy_left = SWEEP;
        idle(SWEEP + 5);

        // Single write to a black pixel, then collide on it.
        wr_px(10, 20, 3'b100); idle(4);
        wr_px(10, 20, 3'b010); idle(4);
        wr_px(10, 20, 3'b000); idle(3);
        wr_px(10, 20, 3'b001); idle(4);

        // Back-to-back writes to the same black pixel.
        wr_px(5, 5, 3'b001);
        wr_px(5, 5, 3'b010);
        idle(4);

        // Out-of-range row, then the last valid cell.
        wr_px(127, 120, 3'b111); idle(3);
        wr_px(127, 119, 3'b101); idle(3);

        // Randomized writes into a small region near the bottom edge.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                wr_px($urandom_range(0, 15), $urandom_range(110, 125), $urandom_range(0, 7));
            else
                idle(1);
        end

        // Full frame with no writes so that every pixel is scanned.
        idle(FRAME + 10);

        // A collision in flight as clear starts, then a clear with a dropped write.
        wr_px(127, 119, 3'b011);
        step(1'b1, 7'd1, 7'd1, 3'b111, 1'b1);
        for (int i = 0; i < 60; i++)
            step(1'b1, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
        idle(SWEEP);

        // Frame after the clear must read back all black.
        idle(FRAME + 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
